// File: rtl/lcd_pixel_position.sv
// LCD timing front end: turns hsync/vsync/de/data into registered pixel coordinates,
// a valid strobe and aligned data, plus per-frame line count and a sticky saturation flag.
module lcd_pixel_position #(
    parameter bit HSYNC_ACTIVE_LOW = 1'b1,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1,
    parameter int DATA_WIDTH       = 16
) (
    input  logic                  pixel_clk_i,
    input  logic                  reset_i,
    input  logic                  lcd_hsync_i,
    input  logic                  lcd_vsync_i,
    input  logic                  lcd_de_i,
    input  logic [DATA_WIDTH-1:0] lcd_data_i,
    output logic [11:0]           pixel_x_o,
    output logic [11:0]           pixel_y_o,
    output logic                  pixel_valid_o,
    output logic [DATA_WIDTH-1:0] pixel_data_o,
    output logic                  frame_start_o,
    output logic [11:0]           line_count_o,
    output logic                  line_count_valid_o,
    output logic                  overflow_o
);

    localparam logic [11:0] CNT_MAX = 12'hFFF;

    logic                  s1_hs_q, s1_hs_d;
    logic                  s1_vs_q, s1_vs_d;
    logic                  s1_de_q, s1_de_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  prev_hs_q, prev_hs_d;
    logic                  prev_vs_q, prev_vs_d;
    logic [11:0]           x_cnt_q, x_cnt_d;
    logic [11:0]           y_cnt_q, y_cnt_d;
    logic                  synced_q, synced_d;

    logic [11:0]           pixel_x_q, pixel_x_d;
    logic [11:0]           pixel_y_q, pixel_y_d;
    logic                  pixel_valid_q, pixel_valid_d;
    logic [DATA_WIDTH-1:0] pixel_data_q, pixel_data_d;
    logic                  frame_start_q, frame_start_d;
    logic [11:0]           line_count_q, line_count_d;
    logic                  line_count_valid_q, line_count_valid_d;
    logic                  overflow_q, overflow_d;

    logic                  hs_edge;
    logic                  vs_edge;
    logic [11:0]           px;
    logic [11:0]           py;

    always_comb begin
        // Normalise sync polarity so everything downstream sees active-high pulses.
        s1_hs_d   = HSYNC_ACTIVE_LOW ? ~lcd_hsync_i : lcd_hsync_i;
        s1_vs_d   = VSYNC_ACTIVE_LOW ? ~lcd_vsync_i : lcd_vsync_i;
        s1_de_d   = lcd_de_i;
        s1_data_d = lcd_data_i;
        prev_hs_d = s1_hs_q;
        prev_vs_d = s1_vs_q;

        hs_edge = s1_hs_q & ~prev_hs_q;
        vs_edge = s1_vs_q & ~prev_vs_q;

        px                 = x_cnt_q;
        py                 = y_cnt_q;
        synced_d           = synced_q;
        line_count_d       = line_count_q;
        line_count_valid_d = line_count_valid_q;
        overflow_d         = overflow_q;

        if (vs_edge) begin
            px                 = 12'd0;
            py                 = 12'd0;
            line_count_d       = y_cnt_q;
            line_count_valid_d = synced_q;
            synced_d           = 1'b1;
        end else if (hs_edge) begin
            px = 12'd0;
            if (y_cnt_q == CNT_MAX) begin
                py         = CNT_MAX;
                overflow_d = 1'b1;
            end else begin
                py = y_cnt_q + 12'd1;
            end
        end

        x_cnt_d = px;
        if (s1_de_q) begin
            if (px == CNT_MAX) begin
                overflow_d = 1'b1;
            end else begin
                x_cnt_d = px + 12'd1;
            end
        end
        y_cnt_d = py;

        // vs_edge term lets the very first pixel of the first frame through.
        pixel_valid_d = s1_de_q & (synced_q | vs_edge);
        pixel_x_d     = px;
        pixel_y_d     = py;
        pixel_data_d  = s1_data_q;
        frame_start_d = vs_edge;
    end

    always_ff @(posedge pixel_clk_i) begin
        if (reset_i) begin
            s1_hs_q            <= 1'b0;
            s1_vs_q            <= 1'b0;
            s1_de_q            <= 1'b0;
            s1_data_q          <= '0;
            prev_hs_q          <= 1'b0;
            prev_vs_q          <= 1'b0;
            x_cnt_q            <= 12'd0;
            y_cnt_q            <= 12'd0;
            synced_q           <= 1'b0;
            pixel_x_q          <= 12'd0;
            pixel_y_q          <= 12'd0;
            pixel_valid_q      <= 1'b0;
            pixel_data_q       <= '0;
            frame_start_q      <= 1'b0;
            line_count_q       <= 12'd0;
            line_count_valid_q <= 1'b0;
            overflow_q         <= 1'b0;
        end else begin
            s1_hs_q            <= s1_hs_d;
            s1_vs_q            <= s1_vs_d;
            s1_de_q            <= s1_de_d;
            s1_data_q          <= s1_data_d;
            prev_hs_q          <= prev_hs_d;
            prev_vs_q          <= prev_vs_d;
            x_cnt_q            <= x_cnt_d;
            y_cnt_q            <= y_cnt_d;
            synced_q           <= synced_d;
            pixel_x_q          <= pixel_x_d;
            pixel_y_q          <= pixel_y_d;
            pixel_valid_q      <= pixel_valid_d;
            pixel_data_q       <= pixel_data_d;
            frame_start_q      <= frame_start_d;
            line_count_q       <= line_count_d;
            line_count_valid_q <= line_count_valid_d;
            overflow_q         <= overflow_d;
        end
    end

    assign pixel_x_o          = pixel_x_q;
    assign pixel_y_o          = pixel_y_q;
    assign pixel_valid_o      = pixel_valid_q;
    assign pixel_data_o       = pixel_data_q;
    assign frame_start_o      = frame_start_q;
    assign line_count_o       = line_count_q;
    assign line_count_valid_o = line_count_valid_q;
    assign overflow_o         = overflow_q;

endmodule

// File: tb/tb_lcd_pixel_position.sv
// Bench for lcd_pixel_position: an active-low and an active-high instance see the same
// timing and are both checked every cycle against a frame/line reference model.
module tb_lcd_pixel_position;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        valid;
        logic [15:0] data;
        logic        fs;
        logic [11:0] lc;
        logic        lcv;
        logic        ovf;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs_a = 1'b1, vs_a = 1'b1, hs_b = 1'b0, vs_b = 1'b0;
    logic        de = 1'b0;
    logic [15:0] din = '0;

    logic [11:0] x_a, y_a, lc_a, x_b, y_b, lc_b;
    logic        valid_a, fs_a, lcv_a, ovf_a, valid_b, fs_b, lcv_b, ovf_b;
    logic [15:0] data_a, data_b;

    int    compared   = 0;
    int    mismatched = 0;
    int    cyc        = 0;
    string phase      = "init";

    // Reference model state (plain integers, saturation via comparison).
    int   m_col, m_row, m_lc;
    bit   m_synced, m_lcv, m_ovf, m_last_hs, m_last_vs;
    out_t exp_cur, exp_next, obs_a, obs_b;

    // Observations of instance A used by directed end-of-scenario checks.
    int fs_cnt, valid_cnt, last_vx, last_vy;

    always #5 clk = ~clk;

    lcd_pixel_position #(.HSYNC_ACTIVE_LOW(1'b1), .VSYNC_ACTIVE_LOW(1'b1), .DATA_WIDTH(16)) dut_a (
        .pixel_clk_i(clk), .reset_i(rst), .lcd_hsync_i(hs_a), .lcd_vsync_i(vs_a),
        .lcd_de_i(de), .lcd_data_i(din), .pixel_x_o(x_a), .pixel_y_o(y_a),
        .pixel_valid_o(valid_a), .pixel_data_o(data_a), .frame_start_o(fs_a),
        .line_count_o(lc_a), .line_count_valid_o(lcv_a), .overflow_o(ovf_a));

    lcd_pixel_position #(.HSYNC_ACTIVE_LOW(1'b0), .VSYNC_ACTIVE_LOW(1'b0), .DATA_WIDTH(16)) dut_b (
        .pixel_clk_i(clk), .reset_i(rst), .lcd_hsync_i(hs_b), .lcd_vsync_i(vs_b),
        .lcd_de_i(de), .lcd_data_i(din), .pixel_x_o(x_b), .pixel_y_o(y_b),
        .pixel_valid_o(valid_b), .pixel_data_o(data_b), .frame_start_o(fs_b),
        .line_count_o(lc_b), .line_count_valid_o(lcv_b), .overflow_o(ovf_b));

    // Consumes the inputs sampled at this edge; their effect shows after the next edge.
    task automatic model_clock(input bit hs, input bit vs, input bit de_in,
                               input logic [15:0] d, input bit r);
        bit vs_rise, hs_rise, v, f;
        int xo;
        if (r) begin
            exp_cur  = '0;
            exp_next = '0;
            m_col = 0; m_row = 0; m_lc = 0;
            m_synced = 0; m_lcv = 0; m_ovf = 0; m_last_hs = 0; m_last_vs = 0;
        end else begin
            exp_cur   = exp_next;
            vs_rise   = vs && !m_last_vs;
            hs_rise   = hs && !m_last_hs;
            m_last_hs = hs;
            m_last_vs = vs;
            f = 0;
            v = de_in && m_synced;
            if (vs_rise) begin
                f = 1; v = de_in;
                m_lc = m_row; m_lcv = m_synced; m_synced = 1;
                m_col = 0; m_row = 0;
            end else if (hs_rise) begin
                m_col = 0;
                if (m_row >= 4095) m_ovf = 1;
                else m_row = m_row + 1;
            end
            xo = m_col;
            if (de_in) begin
                if (m_col >= 4095) m_ovf = 1;
                else m_col = m_col + 1;
            end
            exp_next = {xo[11:0], m_row[11:0], v, d, f, m_lc[11:0], m_lcv, m_ovf};
        end
    endtask

    // One pixel clock; hs/vs are given as logical (asserted = 1) levels.
    task automatic step(input bit hs, input bit vs, input bit de_in, input bit r);
        logic [15:0] d;
        d    = 16'($urandom);
        hs_a = ~hs; vs_a = ~vs;
        hs_b = hs;  vs_b = vs;
        de   = de_in; din = d; rst = r;
        @(posedge clk);
        model_clock(hs, vs, de_in, d, r);
        #1;
        cyc++;
        obs_a = {x_a, y_a, valid_a, data_a, fs_a, lc_a, lcv_a, ovf_a};
        obs_b = {x_b, y_b, valid_b, data_b, fs_b, lc_b, lcv_b, ovf_b};
        compared++;
        assert (obs_a === exp_cur) else begin
            mismatched++;
            $error("FAIL %s cyc%0d low_pol obs=%h exp=%h", phase, cyc, obs_a, exp_cur);
        end
        compared++;
        assert (obs_b === exp_cur) else begin
            mismatched++;
            $error("FAIL %s cyc%0d high_pol obs=%h exp=%h", phase, cyc, obs_b, exp_cur);
        end
        if (fs_a) fs_cnt++;
        if (valid_a) begin
            valid_cnt++;
            last_vx = int'(x_a);
            last_vy = int'(y_a);
        end
    endtask

    task automatic check_val(input string name, input int obs, input int expv);
        compared++;
        assert (obs == expv) else begin
            mismatched++;
            $error("FAIL %s obs=%0d exp=%0d", name, obs, expv);
        end
    endtask

    task automatic line(input int total, input int hs_len, input int de_start,
                        input int de_len, input bit vs);
        for (int c = 0; c < total; c++)
            step(c < hs_len, vs, (c >= de_start) && (c < de_start + de_len), 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Scenario 1: reset, pre-sync lines with DE, then a short 4-line frame.
        phase = "frame4";
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
        fs_cnt = 0; valid_cnt = 0;
        for (int l = 0; l < 2; l++) line(12, 2, 4, 5, 1'b0);
        check_val("presync_valid_cnt", valid_cnt, 0);
        for (int l = 0; l < 4; l++) line(12, 2, 4, (l == 0) ? 0 : 5, l < 3);
        idle(3);
        check_val("frame4_fs_cnt", fs_cnt, 1);
        check_val("frame4_valid_cnt", valid_cnt, 15);
        check_val("frame4_last_x", last_vx, 4);
        check_val("frame4_last_y", last_vy, 3);

        // Scenario 2: two 240-line frames, line count measured from the second vsync on.
        phase = "frame240";
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int l = 0; l < 240; l++) line(8, 1, 3, 3, l == 0);
        check_val("lcv_after_first_frame", int'(lcv_a), 0);
        line(8, 1, 3, 3, 1'b1);
        check_val("lc_second_vsync", int'(lc_a), 239);
        check_val("lcv_second_vsync", int'(lcv_a), 1);
        for (int l = 1; l < 240; l++) line(8, 1, 3, 3, 1'b0);
        check_val("lc_hold", int'(lc_a), 239);

        // Scenario 3: hsync and vsync edges together with DE high.
        phase = "coedge";
        idle(4);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("coedge_x", last_vx, 0);
        check_val("coedge_y", last_vy, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        check_val("coedge_next_x", last_vx, 1);
        check_val("coedge_next_y", last_vy, 0);

        // Scenario 4: 4100-pixel line saturates x and sets the sticky flag.
        phase = "xsat";
        line(4106, 2, 2, 4100, 1'b0);
        check_val("xsat_last_x", last_vx, 4095);
        check_val("xsat_ovf", int'(ovf_a), 1);
        line(20, 2, 4, 5, 1'b0);
        check_val("xsat_ovf_sticky", int'(ovf_a), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("ovf_cleared_by_reset", int'(ovf_a), 0);

        // Scenario 5: reset in the middle of a DE run, then resync on the next vsync.
        phase = "midreset";
        line(10, 1, 2, 6, 1'b1);
        line(10, 1, 2, 6, 1'b0);
        for (int c = 0; c < 4; c++) step(c == 0, 1'b0, c >= 2, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        valid_cnt = 0;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        line(10, 1, 2, 6, 1'b0);
        check_val("midreset_suppressed", valid_cnt, 0);
        line(10, 1, 2, 6, 1'b1);
        idle(2);
        check_val("midreset_resync_y", last_vy, 0);

        // y saturation: more than 4096 hsync pulses with no vsync.
        phase = "ysat";
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int l = 0; l < 4098; l++) line(2, 1, 0, 0, 1'b0);
        check_val("ysat_ovf", int'(ovf_a), 1);

        // Randomised frames with occasional resets.
        phase = "random";
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int fr = 0; fr < 12; fr++) begin
            int nlines, vlines;
            nlines = int'($urandom_range(3, 20));
            vlines = int'($urandom_range(1, 3));
            for (int l = 0; l < nlines; l++) begin
                int total, ds;
                total = int'($urandom_range(6, 30));
                ds    = int'($urandom_range(0, 4));
                if ($urandom_range(0, 40) == 0) step(1'b0, 1'b0, 1'b1, 1'b1);
                line(total, int'($urandom_range(1, 3)), ds,
                     int'($urandom_range(0, total - ds)), l < vlines);
            end
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lcd_pixel_position.md
Name: lcd_pixel_position

Overview:
Front-end stage of the lighting-region mappers. It takes the raw LCD video timing (hsync, vsync, data enable, pixel data) and produces registered pixel coordinates, a pixel-valid strobe and aligned pixel data, all in the pixel clock domain. This is the (pixel_x, pixel_y, pixel_valid) bus consumed by every map_* region block, including the wall-edge mapper. It also reports the per-frame line count and a sticky counter-overflow flag for bring-up diagnostics.

Parameters:
HSYNC_ACTIVE_LOW, 1, 1 = lcd_hsync_i asserted low; 0 = asserted high
VSYNC_ACTIVE_LOW, 1, 1 = lcd_vsync_i asserted low; 0 = asserted high
DATA_WIDTH, 16, width of lcd_data_i / pixel_data_o (16 for RGB565, 24 for RGB888)

Ports:
pixel_clk_i  input  1  LCD pixel clock; the block's only clock
reset_i  input  1  synchronous, active-high reset
lcd_hsync_i  input  1  LCD horizontal sync, polarity per HSYNC_ACTIVE_LOW
lcd_vsync_i  input  1  LCD vertical sync, polarity per VSYNC_ACTIVE_LOW
lcd_de_i  input  1  LCD data enable, active high
lcd_data_i  input  DATA_WIDTH  LCD pixel data
pixel_x_o  output  12  column of the current pixel
pixel_y_o  output  12  line number since vsync; vsync line = 0
pixel_valid_o  output  1  pixel_x_o / pixel_y_o / pixel_data_o describe a real pixel
pixel_data_o  output  DATA_WIDTH  pixel data aligned with the coordinates
frame_start_o  output  1  one-cycle pulse on each vsync assertion edge
line_count_o  output  12  lines counted in the last completed frame
line_count_valid_o  output  1  line_count_o holds a full-frame measurement
overflow_o  output  1  sticky: an x or y counter hit saturation

Behaviour:
- Clock and reset: one clock, pixel_clk_i. reset_i is synchronous and active-high.
- Reset values: all outputs 0. Internal s1 registers 0, x_cnt 0, y_cnt 0, synced 0.
- Stage 1, every cycle: register hsync, vsync, de and data into s1_hs, s1_vs, s1_de, s1_data.
  - Syncs are normalised to active-high using the polarity parameters.
  - The previous s1_hs / s1_vs are also kept.
  - hs_edge = s1_hs & ~prev_hs; vs_edge = s1_vs & ~prev_vs.
- Per-cycle pixel position (px, py) and counter update:
  - vs_edge (takes priority over hs_edge in the same cycle): px = 0, py = 0. Latch line_count_o <= y_cnt. Set line_count_valid_o <= synced. Set synced <= 1.
  - else if hs_edge: px = 0; py = sat(y_cnt + 1).
  - else: px = x_cnt; py = y_cnt.
  - x_cnt <= s1_de ? sat(px + 1) : px.
  - y_cnt <= py.
- Stage 2 outputs, registered:
  - pixel_valid_o <= s1_de & (synced | vs_edge)
  - pixel_x_o <= px; pixel_y_o <= py; pixel_data_o <= s1_data
  - frame_start_o <= vs_edge
- Latency: LCD inputs at cycle n appear on the outputs at cycle n+2. Coordinates, valid and data are always mutually aligned.
- DE on a sync-edge cycle: the pixel is emitted with the post-edge position (x = 0) and x_cnt becomes 1.
- Before the first vsync edge after reset:
  - pixel_valid_o stays 0 even when DE is high.
  - Counters still run.
  - line_count_valid_o stays 0 until the second vsync edge, i.e. the first complete frame.
- Saturation: x_cnt and y_cnt saturate at 4095 and never wrap. Any increment attempted at 4095 sets overflow_o, which stays set until reset_i.
- Held sync level (no new edge): counters are not reset, so a sync stuck asserted behaves as a single edge.
- Reset mid-frame: outputs clear the next cycle. The block resynchronises only at the next vsync edge.
- line_count_o holds its value between vsync edges.

Test Plan:
- Reset, then one frame with active-low syncs: 3 lines of vsync, 4-line total, 5 DE pixels per line. -> pixel_valid_o is 0 until the first vsync edge. After it, pixels appear at y = 1..3 with x = 0..4 and data echoed, each two cycles after input. frame_start_o pulses exactly once.
- Two consecutive 240-line frames. -> line_count_valid_o is 0 after the first vsync and becomes 1 after the second, with line_count_o = 239. The value holds through the frame.
- Hsync and vsync edges on the same cycle, with DE high. -> pixel emitted with x = 0, y = 0. The next DE pixel is x = 1, y = 0.
- Line with 4100 DE cycles. -> pixel_x_o runs to 4095 and stays there, and overflow_o rises and stays 1. Only reset_i clears it.
- Assert reset_i mid-line with DE high. -> all outputs are 0 the next cycle. Pixels are suppressed until the next vsync edge, after which y restarts at 0.
- HSYNC_ACTIVE_LOW = 0, VSYNC_ACTIVE_LOW = 0 with active-high timing. -> the coordinate sequence is identical to scenario 1.
